bam_v8h2_mult_8bits: RTL and testbench

BAM_V8H2_MULT_8BITS -- requirements
Module: bam_v8h2_mult_8bits

---
 rtl/bam_pkg.sv | 31 +++
 rtl/bam_pp_array.sv | 73 +++++++
 rtl/bam_v8h2_mult_8bits.sv | 76 +++++++
 tb/tb_bam_v8h2_mult_8bits.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bam_pkg.sv
// Shared definitions for the broken-array (BAM) approximate multiplier:
// default geometry, product type and the single-bit adder cells.
package bam_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int VBL_DEF   = 8;
    localparam int HBL_DEF   = 2;
    localparam int PROD_W    = 2 * WIDTH_DEF;

    typedef logic [PROD_W-1:0] prod_t;

    typedef struct packed {
        logic c;
        logic s;
    } add_t;

    function automatic add_t half_add(input logic a, input logic b);
        add_t r;
        r.s = a ^ b;
        r.c = a & b;
        return r;
    endfunction

    function automatic add_t full_add(input logic a, input logic b, input logic ci);
        add_t r;
        r.s = a ^ b ^ ci;
        r.c = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/bam_pp_array.sv
// Combinational broken-array reduction: one ripple row of half/full adders per
// kept partial-product row; omitted cells are never instantiated.
module bam_pp_array
    import bam_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int VBL   = VBL_DEF,
    parameter int HBL   = HBL_DEF
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] sum
);

    localparam int PW = 2 * WIDTH;

    // acc[r] is the running sum after rows 0..r-1 have been added.
    logic [WIDTH:0][PW-1:0] acc;

    // Operand bits below the break lines never reach an adder.
    logic [2*WIDTH-1:0] unused_ops;
    assign unused_ops = {A, B};

    assign acc[0] = '0;

    for (genvar r = 0; r < WIDTH; r++) begin : g_row
        // Lowest column in this row that survives both break lines.
        localparam int LO = (VBL > r) ? VBL : r;

        if (r < HBL || r + WIDTH - 1 < VBL || LO > PW - 1) begin : g_skip
            assign acc[r+1] = acc[r];
        end else if (LO == PW - 1) begin : g_top_only
            assign acc[r+1][PW-2:0]  = acc[r][PW-2:0];
            assign acc[r+1][PW-1]    = acc[r][PW-1] ^ (B[r] & A[PW-1-r]);
        end else begin : g_add
            logic [PW-1:LO+1] cy;

            if (LO > 0) begin : g_pass
                assign acc[r+1][LO-1:0] = acc[r][LO-1:0];
            end

            for (genvar c = LO; c < PW; c++) begin : g_col
                localparam bit KEPT = (c - r) <= (WIDTH - 1);

                if (c == LO) begin : g_first
                    add_t o;
                    assign o            = half_add(acc[r][c], B[r] & A[c-r]);
                    assign acc[r+1][c]  = o.s;
                    assign cy[c+1]      = o.c;
                end else if (c == PW - 1) begin : g_msb
                    // The product never exceeds PW bits, so no carry leaves the row.
                    if (KEPT) begin : g_k
                        assign acc[r+1][c] = acc[r][c] ^ (B[r] & A[c-r]) ^ cy[c];
                    end else begin : g_n
                        assign acc[r+1][c] = acc[r][c] ^ cy[c];
                    end
                end else begin : g_mid
                    add_t o;
                    if (KEPT) begin : g_fa
                        assign o = full_add(acc[r][c], B[r] & A[c-r], cy[c]);
                    end else begin : g_ha
                        assign o = half_add(acc[r][c], cy[c]);
                    end
                    assign acc[r+1][c] = o.s;
                    assign cy[c+1]     = o.c;
                end
            end
        end
    end

    assign sum = acc[WIDTH];

endmodule

// File: rtl/bam_v8h2_mult_8bits.sv
// Registered BAM approximate 8x8 multiplier (VBL=8, HBL=2), latency 1.
// Define BAM_V8H2_IN_REG_EN to add an input register stage (latency 2).
module bam_v8h2_mult_8bits
    import bam_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int VBL   = VBL_DEF,
    parameter int HBL   = HBL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output prod_t            P,
    output logic             out_valid
);

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_valid;
    logic [2*WIDTH-1:0] sum;

`ifdef BAM_V8H2_IN_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                a_q <= A;
                b_q <= B;
            end
        end
    end

    assign op_a     = a_q;
    assign op_b     = b_q;
    assign op_valid = v_q;
`else
    assign op_a     = A;
    assign op_b     = B;
    assign op_valid = in_valid;
`endif

    bam_pp_array #(
        .WIDTH (WIDTH),
        .VBL   (VBL),
        .HBL   (HBL)
    ) u_pp_array (
        .A   (op_a),
        .B   (op_b),
        .sum (sum)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            P         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= op_valid;
            if (op_valid) begin
                P <= prod_t'(sum);
            end
        end
    end

endmodule

// File: tb/tb_bam_v8h2_mult_8bits.sv
// Self-checking bench for bam_v8h2_mult_8bits: directed vectors, reset cases,
// back-to-back throughput and a random sweep against a bit-level model.
module tb_bam_v8h2_mult_8bits;

`ifdef BAM_V8H2_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        in_valid;
    logic [15:0] P;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    bam_v8h2_mult_8bits dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .P         (P),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Sum of kept cells: row i >= 2 and column i+j >= 8.
    function automatic int golden(input logic [7:0] a, input logic [7:0] b);
        int s = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (i >= 2 && i + j >= 8 && b[i] && a[j])
                    s += 1 << (i + j);
        return s;
    endfunction

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input int exp, input string tag);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        check({tag, "_p"}, 32'(P), exp);
        check({tag, "_v"}, 32'(out_valid), 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         p;
    } vec_t;

    vec_t dir_vecs[10] = '{
        '{8'd255, 8'd255, 62976},
        '{8'd255, 8'd3,   0},
        '{8'd15,  8'd15,  0},
        '{8'd128, 8'd128, 16384},
        '{8'd16,  8'd16,  256},
        '{8'd255, 8'd4,   768},
        '{8'd2,   8'd128, 256},
        '{8'd1,   8'd128, 0},
        '{8'd255, 8'd128, 32512},
        '{8'd32,  8'd4,   0}
    };

    vec_t b2b[3] = '{
        '{8'd255, 8'd255, 62976},
        '{8'd128, 8'd128, 16384},
        '{8'd255, 8'd4,   768}
    };

    initial begin
        int   n_err_cases = 0;
        int   max_ed      = 0;
        real  sum_ed      = 0.0;
        real  sum_red     = 0.0;
        logic [7:0] ra;
        logic [7:0] rb;
        int   exact;
        int   ed;
        int   idx;

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_p", 32'(P), 0);
        check("reset_v", 32'(out_valid), 0);

        // Reset wins over a simultaneous valid operand.
        A = 8'd255;
        B = 8'd255;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_valid_p", 32'(P), 0);
        check("rst_valid_v", 32'(out_valid), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_drop_v", 32'(out_valid), 0);
        check("rst_drop_p", 32'(P), 0);

        foreach (dir_vecs[k])
            run_one(dir_vecs[k].a, dir_vecs[k].b, dir_vecs[k].p, $sformatf("dir%0d", k));

        // Reset one cycle after an operand is accepted discards it.
        A = 8'd128;
        B = 8'd128;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_p", 32'(P), 0);
        check("mid_rst_v", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("mid_rst_flush_v", 32'(out_valid), 0);
        check("mid_rst_flush_p", 32'(P), 0);

        // Back-to-back operands followed by one idle cycle.
        A = b2b[0].a;
        B = b2b[0].b;
        in_valid = 1'b1;
        for (int t = 0; t < 3 + LAT; t++) begin
            @(posedge clk); #1;
            if (t + 1 < 3) begin
                A = b2b[t+1].a;
                B = b2b[t+1].b;
            end else begin
                in_valid = 1'b0;
            end
            idx = t - (LAT - 1);
            if (idx >= 0 && idx < 3) begin
                check($sformatf("b2b%0d_p", idx), 32'(P), b2b[idx].p);
                check($sformatf("b2b%0d_v", idx), 32'(out_valid), 1);
            end else if (idx == 3) begin
                check("idle_v", 32'(out_valid), 0);
                check("idle_hold_p", 32'(P), b2b[2].p);
            end
        end

        for (int k = 0; k < 10000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_one(ra, rb, golden(ra, rb), "rand");
            exact = int'(ra) * int'(rb);
            check("rand_lsb_zero", 32'(P[7:0]), 0);
            check("rand_bound", 32'(int'(P) <= exact), 1);
            ed = exact - int'(P);
            if (ed != 0) n_err_cases++;
            if (ed > max_ed) max_ed = ed;
            sum_ed += real'(ed);
            if (exact > 0) sum_red += real'(ed) / real'(exact);
        end
        $display("Sweep: error rate %0.4f, mean error distance %0.2f, mean relative error %0.4f, max error %0d",
                 real'(n_err_cases) / 10000.0, sum_ed / 10000.0, sum_red / 10000.0, max_ed);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
